// File: rtl/nx_stream_distributor_pkg.sv
// Shared node constants: message payload type and mesh direction encoding.
package NXConstants;

  localparam int MESSAGE_WIDTH  = 32;
  localparam int NUM_DIRECTIONS = 4;

  typedef logic [MESSAGE_WIDTH-1:0] node_message_t;

  typedef enum logic [1:0] {
    DIRECTION_NORTH = 2'd0,
    DIRECTION_EAST  = 2'd1,
    DIRECTION_SOUTH = 2'd2,
    DIRECTION_WEST  = 2'd3
  } direction_t;

endpackage

// File: rtl/nx_stream_distributor_fifo.sv
// Small register-array FIFO with occupancy counter; head data reads as zero when empty.
module nx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State and storage registers; reset also clears storage so nothing stale survives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/nx_stream_distributor.sv
// Fans one directed inbound stream out to four per-direction FIFOs (N/E/S/W).
module nx_stream_distributor
  import NXConstants::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  node_message_t inbound_data_i,
  input  direction_t    inbound_dir_i,
  input  logic          inbound_valid_i,
  output logic          inbound_ready_o,
  output node_message_t dist_north_data_o,
  output logic          dist_north_valid_o,
  input  logic          dist_north_ready_i,
  output node_message_t dist_east_data_o,
  output logic          dist_east_valid_o,
  input  logic          dist_east_ready_i,
  output node_message_t dist_south_data_o,
  output logic          dist_south_valid_o,
  input  logic          dist_south_ready_i,
  output node_message_t dist_west_data_o,
  output logic          dist_west_valid_o,
  input  logic          dist_west_ready_i,
  output logic          idle_o
);

  logic [NUM_DIRECTIONS-1:0] full, empty, push, pop, out_ready, dir_onehot;
  node_message_t             fifo_data [NUM_DIRECTIONS];
  logic                      accept;

  assign out_ready = {dist_west_ready_i, dist_south_ready_i, dist_east_ready_i, dist_north_ready_i};

  // Ready only looks at the target FIFO, so a full target blocks the whole inbound stream.
  always_comb begin
    inbound_ready_o = !rst_i && !full[inbound_dir_i];
    accept          = inbound_valid_i && inbound_ready_o;
    dir_onehot      = 4'b0001 << inbound_dir_i;
    push            = dir_onehot & {NUM_DIRECTIONS{accept}};
    pop             = ~empty & out_ready & {NUM_DIRECTIONS{!rst_i}};
  end

  for (genvar g = 0; g < NUM_DIRECTIONS; g++) begin : g_fifo
    nx_fifo #(
      .WIDTH (MESSAGE_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .data_i  (inbound_data_i),
      .data_o  (fifo_data[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  assign dist_north_data_o  = fifo_data[DIRECTION_NORTH];
  assign dist_east_data_o   = fifo_data[DIRECTION_EAST];
  assign dist_south_data_o  = fifo_data[DIRECTION_SOUTH];
  assign dist_west_data_o   = fifo_data[DIRECTION_WEST];
  assign dist_north_valid_o = !empty[DIRECTION_NORTH];
  assign dist_east_valid_o  = !empty[DIRECTION_EAST];
  assign dist_south_valid_o = !empty[DIRECTION_SOUTH];
  assign dist_west_valid_o  = !empty[DIRECTION_WEST];
  assign idle_o             = &empty;

endmodule

// File: tb/tb_nx_stream_distributor.sv
// Scoreboard bench: per-direction expected queues fed at acceptance, drained by a monitor.
module tb_nx_stream_distributor;
  import NXConstants::*;

  localparam int DEPTH = 2;

  logic          clk = 0;
  logic          rst = 1;
  node_message_t in_data = '0;
  direction_t    in_dir = DIRECTION_NORTH;
  logic          in_valid = 0;
  logic          in_ready;
  node_message_t d_data [4];
  logic [3:0]    d_valid;
  logic [3:0]    rdy_dir = 4'hF;
  logic [3:0]    rdy_rnd = 4'h0;
  logic          rand_rdy = 0;
  logic [3:0]    d_ready;
  logic          idle;
  logic          chk_en = 0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [4][$];

  assign d_ready = rand_rdy ? rdy_rnd : rdy_dir;

  always #5 clk = ~clk;

  nx_stream_distributor #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .inbound_data_i     (in_data),
    .inbound_dir_i      (in_dir),
    .inbound_valid_i    (in_valid),
    .inbound_ready_o    (in_ready),
    .dist_north_data_o  (d_data[0]),
    .dist_north_valid_o (d_valid[0]),
    .dist_north_ready_i (d_ready[0]),
    .dist_east_data_o   (d_data[1]),
    .dist_east_valid_o  (d_valid[1]),
    .dist_east_ready_i  (d_ready[1]),
    .dist_south_data_o  (d_data[2]),
    .dist_south_valid_o (d_valid[2]),
    .dist_south_ready_i (d_ready[2]),
    .dist_west_data_o   (d_data[3]),
    .dist_west_valid_o  (d_valid[3]),
    .dist_west_ready_i  (d_ready[3]),
    .idle_o             (idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Random downstream readiness, refreshed just after each edge.
  always @(posedge clk) begin
    #1 rdy_rnd = 4'($urandom);
  end

  // Monitor: compare DUT against the queue model, then apply this edge's pops/pushes/reset.
  always @(negedge clk) begin
    if (chk_en) begin
      logic all_empty;
      logic exp_ready;
      all_empty = 1;
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("valid[%0d]", d), 32'(d_valid[d]), 32'(exp_q[d].size() != 0));
        if (exp_q[d].size() != 0) begin
          all_empty = 0;
          chk($sformatf("data[%0d]", d), d_data[d], exp_q[d][0]);
        end else begin
          chk($sformatf("data_zero[%0d]", d), d_data[d], 32'h0);
        end
      end
      chk("idle", 32'(idle), 32'(all_empty));
      exp_ready = !rst && (exp_q[int'(in_dir)].size() < DEPTH);
      chk("inbound_ready", 32'(in_ready), 32'(exp_ready));
      if (rst) begin
        for (int d = 0; d < 4; d++) exp_q[d].delete();
      end else begin
        for (int d = 0; d < 4; d++)
          if (d_ready[d] && exp_q[d].size() != 0) void'(exp_q[d].pop_front());
        if (in_valid && exp_ready) exp_q[int'(in_dir)].push_back(in_data);
      end
    end
  end

  task automatic send(input int dir, input logic [31:0] data);
    int n;
    n = 0;
    in_valid = 1;
    in_dir   = direction_t'(2'(dir));
    in_data  = data;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL send_timeout: dir %0d not accepted after %0d cycles, required acceptance", dir, n);
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset then idle
    @(posedge clk); chk_en = 1;
    cycles(2);
    rst = 0;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'h1);
    chk("idle_after_reset", 32'(idle), 32'h1);
    chk("valids_after_reset", 32'(d_valid), 32'h0);
    cycles(1);

    // Routing to each port
    send(0, 32'h11); send(1, 32'h22); send(2, 32'h33); send(3, 32'h44);
    cycles(3);
    chk("idle_after_routing", 32'(idle), 32'h1);

    // Backpressure / full with head-of-line blocking
    rdy_dir = 4'b1101;
    send(1, 32'hE1); send(1, 32'hE2);
    fork
      begin send(1, 32'hE3); send(0, 32'hA1); end
      begin
        cycles(3);
        @(negedge clk);
        chk("east_full_ready", 32'(in_ready), 32'h0);
        chk("north_blocked", 32'(d_valid[0]), 32'h0);
        @(posedge clk); #1 rdy_dir = 4'hF;
      end
    join
    cycles(4);

    // Simultaneous push and pop on EAST
    rdy_dir = 4'b1101;
    send(1, 32'hB0);
    rdy_dir = 4'hF;
    send(1, 32'hB1);
    rdy_dir = 4'b1101;
    @(negedge clk);
    chk("pushpop_valid", 32'(d_valid[1]), 32'h1);
    chk("pushpop_head", d_data[1], 32'hB1);
    @(posedge clk); #1;
    send(1, 32'hB2);
    in_valid = 1; in_dir = DIRECTION_EAST; in_data = 32'hB3;
    rdy_dir = 4'hF;
    @(negedge clk);
    chk("full_pop_rejects", 32'(in_ready), 32'h0);
    @(posedge clk); #1 in_valid = 0;
    send(1, 32'hB3);
    cycles(4);

    // Pointer wrap on SOUTH with random readiness
    rand_rdy = 1;
    for (int i = 0; i < 20; i++) send(2, 32'h500 + 32'(i));
    // Random mixed traffic
    for (int i = 0; i < 60; i++) begin
      send(int'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 3) == 0) cycles(1);
    end
    rand_rdy = 0; rdy_dir = 4'hF;
    cycles(6);
    chk("drained_idle", 32'(idle), 32'h1);

    // Reset mid-operation discards WEST contents
    rdy_dir = 4'b0111;
    send(3, 32'hC1); send(3, 32'hC2);
    @(negedge clk);
    chk("west_filled", 32'(d_valid[3]), 32'h1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("west_valid_after_rst", 32'(d_valid[3]), 32'h0);
    chk("idle_after_rst", 32'(idle), 32'h1);
    chk("west_data_after_rst", d_data[3], 32'h0);
    rdy_dir = 4'hF;
    cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nx_stream_distributor.md
# nx_stream_distributor

Splits one inbound directed message stream into four outbound per-direction streams (north, east, south, west), each buffered in its own small FIFO. It is the egress-side counterpart of the node's stream combiner: the combiner merges sources into one directed stream, and this block fans that stream out towards the mesh neighbours. Head-of-line blocking on a full target output is by design; non-target outputs continue to drain.

## Interface
- `FIFO_DEPTH`, default 2: entries per output FIFO; power of two, 2..16.
- `clk_i` input, 1 bit: clock.
- `rst_i` input, 1 bit: one clock; reset is synchronous and active-high.
- `inbound_data_i` input, node_message_t: message to route.
- `inbound_dir_i` input, direction_t: target output.
- `inbound_valid_i` input, 1 bit: inbound message present.
- `inbound_ready_o` output, 1 bit: inbound accepted this cycle when high with `inbound_valid_i`.
- `dist_north_data_o`, `dist_east_data_o`, `dist_south_data_o`, `dist_west_data_o` output, node_message_t: head-of-FIFO message.
- `dist_north_valid_o` (east, south and west likewise) output, 1 bit: FIFO non-empty.
- `dist_north_ready_i` (east, south and west likewise) input, 1 bit: downstream consumes the head.
- `idle_o` output, 1 bit: all four FIFOs empty.

## Operation
- Push: `inbound_valid_i && inbound_ready_o` writes data into the FIFO selected by `inbound_dir_i` (NORTH=0, EAST=1, SOUTH=2, WEST=3).
- `inbound_ready_o = !rst_i && !full[inbound_dir_i]`. Ready depends combinationally on `inbound_dir_i` only, never on any `dist_*_ready_i`. The source holds data and dir stable while valid is high and not accepted.
- Pop: per output, `valid && ready_i` advances the read pointer. All four outputs pop independently in the same cycle.
- Each FIFO is a `FIFO_DEPTH`-entry register array with read/write pointers of width log2(`FIFO_DEPTH`), wrapping modulo depth, plus an occupancy counter of width log2(`FIFO_DEPTH`)+1.
  - full = (count == `FIFO_DEPTH`); empty = (count == 0).
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance.
- A full FIFO rejects a push even if it pops in the same cycle. There is no ready pass-through.
- Output data is driven from storage at the read pointer. Data is all-zero when empty.
- `idle_o` = AND of all empty flags (registered-derived, no input dependency).

## Timing
- Reset (synchronous, `rst_i` high at a clock edge) clears pointers and counters and zeroes storage.
  - Reset values: all `dist_*_valid_o`=0, all `dist_*_data_o`=0, `idle_o`=1, `inbound_ready_o`=0 while `rst_i` is high.
- Reset asserted mid-operation discards all buffered messages. No pop is reported in the reset cycle.
- Latency: a message accepted at edge N is visible on `dist_<dir>_valid_o` after edge N (cycle N+1). There is no same-cycle bypass.
- Throughput: one message per cycle into any output that is not full. With depth ≥ 2, a continuously-ready output sustains full rate.
- Per-output ordering is strictly FIFO. No ordering holds across outputs.

## Structure
- `node_message_t`, `direction_t`, `MESSAGE_WIDTH` and the `DIRECTION_*` encodings come from the NXConstants package. No new package types are needed.
- Natural sub-module: `nx_fifo` (parameters WIDTH and DEPTH; push, pop, data, full, empty), instantiated four times via a generate loop indexed by direction.
- The top level holds only dir decode, ready mux, valid/ready wiring and `idle_o`.

## Test plan
- Reset then idle: after reset, all valids are 0, `idle_o`=1, `inbound_ready_o`=1 on the cycle after `rst_i` drops.
- Routing: send messages 0x11 N, 0x22 E, 0x33 S, 0x44 W with all outputs ready.
  - Each appears on only its own port one cycle after acceptance.
  - `idle_o` returns to 1.
- Backpressure/full: hold `dist_east_ready_i`=0 and send 3 messages to EAST with depth 2.
  - The first two are accepted; `inbound_ready_o`=0 for the third.
  - A NORTH message offered meanwhile is not accepted until EAST pops (head-of-line blocking).
  - Releasing ready yields the EAST messages in order.
- Simultaneous push and pop: EAST holds 1 entry; push and pop EAST in the same cycle.
  - Count stays 1 and the new head is the pushed message.
  - A push while full with a concurrent pop is rejected.
- Pointer wrap: stream 20 sequential values to SOUTH with random ready.
  - Output sequence matches input exactly and no value is lost or duplicated.
- Reset mid-operation: fill WEST with 2 entries and assert `rst_i` for one cycle.
  - `dist_west_valid_o`=0, `idle_o`=1 afterwards, and no stale data is emitted.
